// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - one-hot compare encodings and operand extension helper for comp_pipe
package comp_pkg;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT      = 3'b100;
    localparam cmp_res_t CMP_LT      = 3'b010;
    localparam cmp_res_t CMP_EQ      = 3'b001;
    localparam int       MAX_LATENCY = 8;

    // Bit prepended above the operand MSB: the sign in signed mode, zero otherwise.
    function automatic logic cmp_sext(input logic msb, input logic signed_mode);
        return msb & signed_mode;
    endfunction

endpackage

// File: rtl/comp_cell.sv
// rtl/comp_cell.sv - combinational single-lane signed/unsigned magnitude compare
module comp_cell
    import comp_pkg::*;
#(
    parameter int DATAWIDTH = 8
)
(
    input  logic [DATAWIDTH-1:0] i_a,
    input  logic [DATAWIDTH-1:0] i_b,
    input  logic                 i_signed_mode,
    output cmp_res_t             o_res
);

    logic signed [DATAWIDTH:0] w_a_ext;
    logic signed [DATAWIDTH:0] w_b_ext;

    // One extra bit lets a single signed comparator serve both modes.
    assign w_a_ext = {cmp_sext(i_a[DATAWIDTH-1], i_signed_mode), i_a};
    assign w_b_ext = {cmp_sext(i_b[DATAWIDTH-1], i_signed_mode), i_b};

    always_comb begin
        if (w_a_ext > w_b_ext) begin
            o_res = CMP_GT;
        end else if (w_a_ext < w_b_ext) begin
            o_res = CMP_LT;
        end else begin
            o_res = CMP_EQ;
        end
    end

endmodule

// File: rtl/comp_pipe.sv
// rtl/comp_pipe.sv - multi-channel pipelined comparator with valid/ready on both sides
// Define COMP_MINMAX_EN to add per-channel running min/max trackers of operand a.
module comp_pipe
    import comp_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int LATENCY   = 2
)
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [NUM_CH*DATAWIDTH-1:0] i_a,
    input  logic [NUM_CH*DATAWIDTH-1:0] i_b,
    input  logic                        i_signed_mode,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [NUM_CH-1:0]           o_gt,
    output logic [NUM_CH-1:0]           o_lt,
    output logic [NUM_CH-1:0]           o_eq
`ifdef COMP_MINMAX_EN
    ,
    input  logic                        i_stat_clr,
    output logic [NUM_CH*DATAWIDTH-1:0] o_min_a,
    output logic [NUM_CH*DATAWIDTH-1:0] o_max_a
`endif
);

`ifdef COMP_MINMAX_EN
    localparam int PW = 3*NUM_CH + NUM_CH*DATAWIDTH + 1;
`else
    localparam int PW = 3*NUM_CH;
`endif

    logic                w_adv;
    cmp_res_t            w_res [NUM_CH];
    logic [NUM_CH-1:0]   w_gt;
    logic [NUM_CH-1:0]   w_lt;
    logic [NUM_CH-1:0]   w_eq;
    logic [PW-1:0]       w_pay_in;
    logic [LATENCY-1:0]  w_vld_nxt;
    logic [PW-1:0]       w_pay_nxt [LATENCY];
    logic [LATENCY-1:0]  r_vld;
    logic [PW-1:0]       r_pay [LATENCY];

    assign w_adv       = !r_vld[LATENCY-1] || i_out_ready;
    assign o_in_ready  = w_adv;
    assign o_out_valid = r_vld[LATENCY-1];
    assign {o_gt, o_lt, o_eq} = r_pay[LATENCY-1][3*NUM_CH-1:0];

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cell
        comp_cell #(.DATAWIDTH(DATAWIDTH)) u_cell (
            .i_a           (i_a[ch*DATAWIDTH +: DATAWIDTH]),
            .i_b           (i_b[ch*DATAWIDTH +: DATAWIDTH]),
            .i_signed_mode (i_signed_mode),
            .o_res         (w_res[ch])
        );
        assign w_gt[ch] = (w_res[ch] == CMP_GT);
        assign w_lt[ch] = (w_res[ch] == CMP_LT);
        assign w_eq[ch] = (w_res[ch] == CMP_EQ);
    end

`ifdef COMP_MINMAX_EN
    assign w_pay_in = {i_signed_mode, i_a, w_gt, w_lt, w_eq};
`else
    assign w_pay_in = {w_gt, w_lt, w_eq};
`endif

    always_comb begin
        w_vld_nxt[0] = i_in_valid;
        w_pay_nxt[0] = w_pay_in;
        for (int s = 1; s < LATENCY; s++) begin
            w_vld_nxt[s] = r_vld[s-1];
            w_pay_nxt[s] = r_pay[s-1];
        end
    end

    // Payload only loads behind a valid beat, so results hold across bubbles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_pay[s] <= '0;
            end
        end else if (w_adv) begin
            r_vld <= w_vld_nxt;
            for (int s = 0; s < LATENCY; s++) begin
                if (w_vld_nxt[s]) begin
                    r_pay[s] <= w_pay_nxt[s];
                end
            end
        end
    end

`ifdef COMP_MINMAX_EN
    logic [NUM_CH*DATAWIDTH-1:0] w_out_a;
    logic                        w_out_mode;
    logic                        w_xfer;

    assign {w_out_mode, w_out_a} = r_pay[LATENCY-1][PW-1:3*NUM_CH];
    assign w_xfer = r_vld[LATENCY-1] && i_out_ready;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_trk
        logic                 r_seen;
        logic [DATAWIDTH-1:0] r_min;
        logic [DATAWIDTH-1:0] r_max;
        logic [DATAWIDTH-1:0] w_lane;
        cmp_res_t             w_vs_min;
        cmp_res_t             w_vs_max;

        assign w_lane = w_out_a[ch*DATAWIDTH +: DATAWIDTH];

        comp_cell #(.DATAWIDTH(DATAWIDTH)) u_min_cmp (
            .i_a(w_lane), .i_b(r_min), .i_signed_mode(w_out_mode), .o_res(w_vs_min)
        );
        comp_cell #(.DATAWIDTH(DATAWIDTH)) u_max_cmp (
            .i_a(w_lane), .i_b(r_max), .i_signed_mode(w_out_mode), .o_res(w_vs_max)
        );

        // Clear takes precedence, so a coincident transfer becomes the first sample.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_seen <= 1'b0;
                r_min  <= '0;
                r_max  <= '0;
            end else if (w_xfer && (i_stat_clr || !r_seen)) begin
                r_seen <= 1'b1;
                r_min  <= w_lane;
                r_max  <= w_lane;
            end else if (i_stat_clr) begin
                r_seen <= 1'b0;
                r_min  <= '0;
                r_max  <= '0;
            end else if (w_xfer) begin
                if (w_vs_min == CMP_LT) r_min <= w_lane;
                if (w_vs_max == CMP_GT) r_max <= w_lane;
            end
        end

        assign o_min_a[ch*DATAWIDTH +: DATAWIDTH] = r_min;
        assign o_max_a[ch*DATAWIDTH +: DATAWIDTH] = r_max;
    end
`endif

endmodule
